// File: rtl/switch_block_cfg_pkg.sv
// Shared types and constants for the scan-configured routing switch block.
package switch_block_cfg_pkg;

  typedef enum logic [1:0] {
    SideL = 2'd0,
    SideT = 2'd1,
    SideR = 2'd2,
    SideB = 2'd3
  } side_e;

  localparam logic [1:0] CodeStraight = 2'b00;
  localparam logic [1:0] CodeCw       = 2'b01;
  localparam logic [1:0] CodeCcw      = 2'b10;
  localparam logic [1:0] CodeTap      = 2'b11;

  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StLoad  = 2'b01,
    StFull  = 2'b10,
    StOver  = 2'b11
  } cfg_state_e;

endpackage

// File: rtl/sb_track_mux.sv
// One routing track output: 4:1 select driven by a 2-bit control code.
module sb_track_mux
  import switch_block_cfg_pkg::*;
(
  input  logic [1:0] sel_i,
  input  logic [3:0] in_i,
  output logic       out_o
);

  always_comb begin
    out_o = 1'b0;
    unique case (sel_i)
      CodeStraight: out_o = in_i[0];
      CodeCw:       out_o = in_i[1];
      CodeCcw:      out_o = in_i[2];
      CodeTap:      out_o = in_i[3];
      default:      out_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/switch_block_cfg.sv
// Scan-configured FPGA switch block: shadow scan chain, checked commit into an
// active config, and a per-track mux fabric gated by cfg_valid.
module switch_block_cfg
  import switch_block_cfg_pkg::*;
#(
  parameter int unsigned CHANNEL_WIDTH = 8,
  parameter int unsigned REG_OUT       = 0,
  localparam int unsigned W            = CHANNEL_WIDTH / 2,
  localparam int unsigned CFG_BITS     = 8 * W
) (
  input  logic         scan_clk,
  input  logic         reset,
  input  logic [W-1:0] left_in,
  input  logic [W-1:0] top_in,
  input  logic [W-1:0] right_in,
  input  logic [W-1:0] bottom_in,
  output logic [W-1:0] left_out,
  output logic [W-1:0] top_out,
  output logic [W-1:0] right_out,
  output logic [W-1:0] bottom_out,
  input  logic [3:0]   clb_in,
  input  logic         scan_in,
  input  logic         scan_en,
  output logic         scan_out,
  input  logic         cfg_commit,
  input  logic         cfg_parity,
  output logic         cfg_valid,
  output logic         cfg_err,
  output logic [1:0]   cfg_state
);

  localparam int unsigned CntW = $clog2(CFG_BITS + 2);
  localparam logic [CntW-1:0] CntFull = CntW'(CFG_BITS);
  localparam logic [CntW-1:0] CntMax  = CntW'(CFG_BITS + 1);

  logic [CFG_BITS-1:0] shadow_q, shadow_d;
  logic [CFG_BITS-1:0] active_q, active_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  cfg_state_e          state_q, state_d;
  logic                accept;

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    err_d    = err_q;
    state_d  = state_q;
    accept   = cfg_commit && !scan_en && (state_q == StFull) && (cfg_parity == ^shadow_q);

    if (scan_en) begin
      shadow_d = {shadow_q[CFG_BITS-2:0], scan_in};
      // A fresh load (from empty or after overrun) restarts the count and forgives old errors.
      if (state_q == StEmpty || state_q == StOver) begin
        cnt_d = CntW'(1);
        err_d = 1'b0;
      end else if (cnt_q != CntMax) begin
        cnt_d = cnt_q + CntW'(1);
      end
    end

    if (accept) begin
      active_d = shadow_q;
      valid_d  = 1'b1;
      cnt_d    = '0;
    end else if (cfg_commit) begin
      err_d = 1'b1;
    end

    if (cnt_d == '0) begin
      state_d = StEmpty;
    end else if (cnt_d < CntFull) begin
      state_d = StLoad;
    end else if (cnt_d == CntFull) begin
      state_d = StFull;
    end else begin
      state_d = StOver;
    end
  end

  always_ff @(posedge scan_clk) begin
    if (reset) begin
      shadow_q <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      state_q  <= StEmpty;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      state_q  <= state_d;
    end
  end

  assign scan_out  = shadow_q[CFG_BITS-1];
  assign cfg_valid = valid_q;
  assign cfg_err   = err_q;
  assign cfg_state = state_q;

  // Side-major flattening: side s, track i lives at s*W+i.
  logic [4*W-1:0] in_all;
  logic [4*W-1:0] route;
  logic [4*W-1:0] route_gated;
  logic [4*W-1:0] route_out;

  assign in_all = {bottom_in, right_in, top_in, left_in};

  for (genvar s = 0; s < 4; s++) begin : g_side
    for (genvar i = 0; i < W; i++) begin : g_track
      localparam int unsigned SrcStr = (s + 2) % 4;
      localparam int unsigned SrcCw  = (s + 1) % 4;
      localparam int unsigned SrcCcw = (s + 3) % 4;

      logic       tap;
      logic [3:0] mux_in;

      assign tap    = (i == W - 1) ? clb_in[s] : 1'b0;
      assign mux_in = {tap,
                       in_all[SrcCcw*W + (i+1)%W],
                       in_all[SrcCw*W + (W-1-i)],
                       in_all[SrcStr*W + i]};

      sb_track_mux u_mux (
        .sel_i (active_q[2*(s*W+i) +: 2]),
        .in_i  (mux_in),
        .out_o (route[s*W+i])
      );
    end
  end

  assign route_gated = valid_q ? route : '0;

  if (REG_OUT != 0) begin : g_reg_out
    logic [4*W-1:0] out_q;
    always_ff @(posedge scan_clk) begin
      if (reset) begin
        out_q <= '0;
      end else begin
        out_q <= route_gated;
      end
    end
    assign route_out = out_q;
  end else begin : g_comb_out
    assign route_out = route_gated;
  end

  assign left_out   = route_out[0*W +: W];
  assign top_out    = route_out[1*W +: W];
  assign right_out  = route_out[2*W +: W];
  assign bottom_out = route_out[3*W +: W];

endmodule

// File: tb/tb_switch_block_cfg.sv
// Scoreboard bench for switch_block_cfg (W=4): combinational and registered-output builds.
module tb_switch_block_cfg;

  localparam int W = 4;

  localparam int SelValid0 = 0;
  localparam int SelErr0   = 1;
  localparam int SelState0 = 2;
  localparam int SelLeft0  = 3;
  localparam int SelTop0   = 4;
  localparam int SelRight0 = 5;
  localparam int SelBot0   = 6;
  localparam int SelScan0  = 7;
  localparam int SelAll0   = 8;
  localparam int SelRight1 = 9;
  localparam int SelBot1   = 10;
  localparam int SelAll1   = 11;
  localparam int SelValid1 = 12;

  logic         scan_clk = 1'b0;
  logic         reset;
  logic [W-1:0] left_in, top_in, right_in, bottom_in;
  logic [3:0]   clb_in;
  logic         scan_in, scan_en, cfg_commit, cfg_parity;

  logic [W-1:0] l0, t0, r0, b0, l1, t1, r1, b1;
  logic         so0, v0, e0, so1, v1, e1;
  logic [1:0]   st0, st1;

  always #5 scan_clk = ~scan_clk;

  switch_block_cfg #(.CHANNEL_WIDTH(2*W), .REG_OUT(0)) dut0 (
    .scan_clk(scan_clk), .reset(reset),
    .left_in(left_in), .top_in(top_in), .right_in(right_in), .bottom_in(bottom_in),
    .left_out(l0), .top_out(t0), .right_out(r0), .bottom_out(b0),
    .clb_in(clb_in), .scan_in(scan_in), .scan_en(scan_en), .scan_out(so0),
    .cfg_commit(cfg_commit), .cfg_parity(cfg_parity),
    .cfg_valid(v0), .cfg_err(e0), .cfg_state(st0)
  );

  switch_block_cfg #(.CHANNEL_WIDTH(2*W), .REG_OUT(1)) dut1 (
    .scan_clk(scan_clk), .reset(reset),
    .left_in(left_in), .top_in(top_in), .right_in(right_in), .bottom_in(bottom_in),
    .left_out(l1), .top_out(t1), .right_out(r1), .bottom_out(b1),
    .clb_in(clb_in), .scan_in(scan_in), .scan_en(scan_en), .scan_out(so1),
    .cfg_commit(cfg_commit), .cfg_parity(cfg_parity),
    .cfg_valid(v1), .cfg_err(e1), .cfg_state(st1)
  );

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  chk_t q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      SelValid0: return 32'(v0);
      SelErr0:   return 32'(e0);
      SelState0: return 32'(st0);
      SelLeft0:  return 32'(l0);
      SelTop0:   return 32'(t0);
      SelRight0: return 32'(r0);
      SelBot0:   return 32'(b0);
      SelScan0:  return 32'(so0);
      SelAll0:   return 32'({l0, t0, r0, b0});
      SelRight1: return 32'(r1);
      SelBot1:   return 32'(b1);
      SelAll1:   return 32'({l1, t1, r1, b1, so1, e1, st1});
      SelValid1: return 32'(v1);
      default:   return 32'hdead_beef;
    endcase
  endfunction

  task automatic push_chk(input string name, input int sel, input logic [31:0] exp);
    chk_t c;
    c.name = name;
    c.sel  = sel;
    c.exp  = exp;
    q.push_back(c);
  endtask

  // Monitor: everything queued since the last falling edge is compared mid-cycle.
  always @(negedge scan_clk) begin
    while (q.size() != 0) begin
      chk_t        c;
      logic [31:0] act;
      c   = q.pop_front();
      act = actual(c.sel);
      total++;
      if (act !== c.exp) begin
        bad++;
        $display("FAIL %s: got %h want %h", c.name, act, c.exp);
      end
    end
  end

  task automatic tick();
    @(posedge scan_clk);
    #1;
  endtask

  task automatic shift_bits(input logic [63:0] v, input int n);
    for (int k = n - 1; k >= 0; k--) begin
      scan_en = 1'b1;
      scan_in = v[k];
      tick();
    end
    scan_en = 1'b0;
    scan_in = 1'b0;
  endtask

  task automatic commit(input logic par);
    cfg_commit = 1'b1;
    cfg_parity = par;
    tick();
    cfg_commit = 1'b0;
    cfg_parity = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    left_in    = '0;
    top_in     = '0;
    right_in   = '0;
    bottom_in  = '0;
    clb_in     = '0;
    scan_in    = 1'b0;
    scan_en    = 1'b0;
    cfg_commit = 1'b0;
    cfg_parity = 1'b0;
    tick();
    tick();
    push_chk("rst_valid", SelValid0, 0);
    push_chk("rst_err", SelErr0, 0);
    push_chk("rst_state", SelState0, 0);
    push_chk("rst_outs0", SelAll0, 0);
    push_chk("rst_scan_out", SelScan0, 0);
    push_chk("rst_outs1", SelAll1, 0);
    reset = 1'b0;

    // All-straight config, then straight-through routing.
    shift_bits(64'h0, 32);
    push_chk("t1_full", SelState0, 2);
    commit(1'b0);
    push_chk("t1_valid", SelValid0, 1);
    push_chk("t1_empty", SelState0, 0);
    push_chk("t1_err", SelErr0, 0);
    left_in = 4'hA;
    top_in  = 4'h3;
    push_chk("t1_right", SelRight0, 32'hA);
    push_chk("t1_bottom", SelBot0, 32'h3);
    push_chk("t1_reg_right_early", SelRight1, 32'h0);
    tick();
    push_chk("t1_reg_right", SelRight1, 32'hA);
    push_chk("t1_reg_bottom", SelBot1, 32'h3);

    // Left side all tap code: only track 3 follows clb_in[0].
    shift_bits(64'h0000_00FF, 32);
    push_chk("t2_full", SelState0, 2);
    push_chk("t2_shift_keeps_route", SelRight0, 32'hA);
    push_chk("t2_scan_out", SelScan0, 0);
    commit(1'b0);
    clb_in = 4'b0001;
    push_chk("t2_tap_hi", SelLeft0, 32'h8);
    push_chk("t2_right_kept", SelRight0, 32'hA);
    tick();
    clb_in = 4'b1110;
    push_chk("t2_tap_lo", SelLeft0, 32'h0);
    tick();
    clb_in = 4'b0001;

    // Short load (31 bits) is rejected; the 32nd bit makes it acceptable.
    shift_bits(64'h0000_0055 >> 1, 31);
    push_chk("t3_load", SelState0, 1);
    commit(1'b0);
    push_chk("t3_err", SelErr0, 1);
    push_chk("t3_valid", SelValid0, 1);
    push_chk("t3_state_kept", SelState0, 1);
    push_chk("t3_old_route", SelLeft0, 32'h8);
    shift_bits(64'h0000_0055, 1);
    push_chk("t3_full", SelState0, 2);
    commit(1'b0);
    push_chk("t3_accept_state", SelState0, 0);
    push_chk("t3_err_sticky", SelErr0, 1);
    push_chk("t3_cw_left", SelLeft0, 32'hC);

    // Overrun: 33 bits, commit rejected, next shift restarts.
    shift_bits(64'h0_8000_0000, 33);
    push_chk("t4_over", SelState0, 3);
    push_chk("t4_err_cleared", SelErr0, 0);
    push_chk("t4_scan_out", SelScan0, 1);
    commit(1'b0);
    push_chk("t4_err", SelErr0, 1);
    push_chk("t4_state_kept", SelState0, 3);
    push_chk("t4_old_route", SelLeft0, 32'hC);
    shift_bits(64'h00AA_0000 >> 31, 1);
    push_chk("t4_restart_err", SelErr0, 0);
    push_chk("t4_restart_cnt", SelState0, 1);
    shift_bits(64'h00AA_0000, 31);
    push_chk("t5_full", SelState0, 2);

    // Bad parity, then commit during shift: both rejected.
    commit(1'b1);
    push_chk("t5_par_err", SelErr0, 1);
    push_chk("t5_par_state", SelState0, 2);
    push_chk("t5_par_route", SelLeft0, 32'hC);
    scan_en    = 1'b1;
    scan_in    = 1'b0;
    cfg_commit = 1'b1;
    tick();
    scan_en    = 1'b0;
    cfg_commit = 1'b0;
    push_chk("t5_scan_commit_err", SelErr0, 1);
    push_chk("t5_scan_commit_shifted", SelState0, 3);
    push_chk("t5_scan_commit_route", SelLeft0, 32'hC);
    shift_bits(64'h00AA_0000, 32);
    commit(1'b0);
    push_chk("t5_accept", SelState0, 0);
    push_chk("t5_ccw_right", SelRight0, 32'h9);
    right_in = 4'h5;
    push_chk("t5_left_straight", SelLeft0, 32'h5);

    // Reset mid-load, with commit and scan_en asserted in the same cycle.
    shift_bits(64'h00AA_0000, 10);
    reset      = 1'b1;
    cfg_commit = 1'b1;
    scan_en    = 1'b1;
    scan_in    = 1'b1;
    left_in    = 4'hC;
    tick();
    push_chk("t6_valid", SelValid0, 0);
    push_chk("t6_err", SelErr0, 0);
    push_chk("t6_state", SelState0, 0);
    push_chk("t6_outs0", SelAll0, 0);
    push_chk("t6_outs1", SelAll1, 0);
    push_chk("t6_valid1", SelValid1, 0);
    reset      = 1'b0;
    cfg_commit = 1'b0;
    scan_en    = 1'b0;
    scan_in    = 1'b0;

    // Registered build lags the combinational one by exactly one cycle.
    shift_bits(64'h0, 32);
    commit(1'b0);
    push_chk("t7_comb_cfg", SelRight0, 32'hC);
    push_chk("t7_reg_cfg_early", SelRight1, 32'h0);
    tick();
    push_chk("t7_reg_cfg", SelRight1, 32'hC);
    left_in = 4'h3;
    push_chk("t7_comb_data", SelRight0, 32'h3);
    push_chk("t7_reg_data_early", SelRight1, 32'hC);
    tick();
    push_chk("t7_reg_data", SelRight1, 32'h3);

    tick();
    @(negedge scan_clk);
    #1;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL unchecked_queue: got %0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/switch_block_cfg.md
SWITCH_BLOCK_CFG -- requirements
Module: switch_block_cfg

Interface
REQ-001 SHALL have parameter CHANNEL_WIDTH, default 8, meaning total channel width; even, >=4; W = CHANNEL_WIDTH/2 tracks per side.
REQ-002 SHALL have parameter REG_OUT, default 0, meaning 1 = registered outputs, 0 = combinational outputs.
REQ-003 SHALL have localparam CFG_BITS = 8*W, meaning configuration bits (4 sides x W tracks x 2).
REQ-004 SHALL have ports: scan_clk  in  1  sole clock, rising edge; reset  in  1  synchronous, active-high.
REQ-005 SHALL have ports: left_in, top_in, right_in, bottom_in  in  W each  routing track inputs.
REQ-006 SHALL have ports: left_out, top_out, right_out, bottom_out  out  W each  routing track outputs.
REQ-007 SHALL have ports: clb_in  in  4  CLB taps, index L=0, T=1, R=2, B=3.
REQ-008 SHALL have ports: scan_in  in  1, scan_en  in  1, scan_out  out  1  configuration scan chain.
REQ-009 SHALL have ports: cfg_commit  in  1  single-cycle commit request; cfg_parity  in  1  expected even parity of the shadow register.
REQ-010 SHALL have ports: cfg_valid  out  1  active config loaded; cfg_err  out  1  sticky load error; cfg_state  out  2  load FSM state.

Function
REQ-011 Shadow register: on each scan_en cycle SHALL shift left, scan_in entering bit 0; scan_out SHALL equal shadow[CFG_BITS-1].
REQ-012 Control fields SHALL be shadow/active bits [2(sW+i)+1 : 2(sW+i)] for side s (L=0, T=1, R=2, B=3) and track i.
REQ-013 Output side s, track i SHALL select by its 2-bit control code: 00 = in[(s+2)%4][i]; 01 = in[(s+1)%4][W-1-i]; 10 = in[(s+3)%4][(i+1)%W].
REQ-014 Code 11 on side s SHALL select clb_in[s] for track W-1 and constant 0 for every other track.
REQ-015 While cfg_valid=0, all track outputs SHALL be 0.
REQ-016 Bit counter SHALL count scan_en cycles since the last clear and saturate at CFG_BITS+1.
REQ-017 FSM states SHALL be EMPTY=00 (count 0), LOAD=01 (0<count<CFG_BITS), FULL=10 (count=CFG_BITS) and OVER=11 (count>CFG_BITS); cfg_state SHALL equal the state.
REQ-018 A commit SHALL be accepted iff cfg_commit=1, scan_en=0, state=FULL and cfg_parity equals XOR of all shadow bits.
REQ-019 An accepted commit SHALL copy shadow to active on that edge, set cfg_valid=1, clear the counter (EMPTY) and leave the shadow unchanged.
REQ-020 A rejected commit SHALL leave active, cfg_valid and counter unchanged and set cfg_err=1; this includes commit with scan_en=1, a wrong state, or a parity mismatch.
REQ-021 The first scan_en cycle from EMPTY or OVER SHALL clear cfg_err.
REQ-022 scan_en from OVER SHALL restart the count at 1.
REQ-023 Latency: with REG_OUT=0 outputs SHALL reflect new active config in the cycle after the commit edge and data combinationally; with REG_OUT=1 one additional cycle for both.
REQ-024 Shifting SHALL never disturb the active config or live routing.

Reset
REQ-025 Reset SHALL clear shadow, active (all 0), counter, cfg_valid and cfg_err, and set state to EMPTY.
REQ-026 All outputs SHALL be 0 the cycle after reset, including output registers when REG_OUT=1.
REQ-027 Reset SHALL dominate scan_en and cfg_commit in the same cycle.
REQ-028 Reset mid-load SHALL abandon the load.

Structure
REQ-029 A shared package SHALL hold the side enum (L, T, R, B), the control-code constants (STRAIGHT=00, CW=01, CCW=10, TAP=11) and the cfg_state enum.
REQ-030 One sub-module, sb_track_mux (4:1, 2-bit control), SHALL be instantiated 4*W times via generate.
REQ-031 Scan/commit logic SHALL stay in the top level.

Verification
REQ-032 W=4: shift 32 bits of all-00 with correct parity, commit -> cfg_valid=1, state EMPTY; left_in=4'hA -> right_out=4'hA next cycle.
REQ-033 Load L track 3 = 11, commit, toggle clb_in[0] -> left_out[3] follows; left_out[0..2] with code 11 = 0.
REQ-034 Shift 31 bits then commit -> cfg_err=1, cfg_valid unchanged, outputs still old routing; one more bit then a good commit -> accepted.
REQ-035 Shift 33 bits -> state OVER; commit -> cfg_err=1; next scan_en -> cfg_err=0, count=1.
REQ-036 Wrong cfg_parity at FULL -> rejected; commit with scan_en=1 -> rejected, shift still occurs.
REQ-037 Reset asserted mid-load and in the same cycle as commit -> all outputs 0, cfg_valid=0, state EMPTY; REG_OUT=1 build shows exactly +1 cycle latency.
